// File: rtl/p10_uart_tx.sv
// UART transmitter with a one-word holding register and active-low CTS flow control.
// Each frame is a start bit, PAYLOAD_BITS data bits sent LSB-first, then STOP_BITS stop bits.
module p10_uart_tx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    uart_txd,
  input  logic                    uart_cts,
  input  logic                    uart_tx_valid,
  output logic                    uart_tx_ready,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_busy
);

  localparam int BIT_NS         = 1_000_000_000 / BIT_RATE;
  localparam int CLK_NS         = 1_000_000_000 / CLK_HZ;
  localparam int CYCLES_PER_BIT = BIT_NS / CLK_NS;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT) + 1;
  localparam int MAX_BITS       = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
  localparam int IDX_W          = $clog2(MAX_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [PAYLOAD_BITS-1:0] shift, shift_n;
  logic [PAYLOAD_BITS-1:0] hold, hold_n;
  logic                    hold_full, hold_full_n;
  logic                    txd_q, txd_n;
  logic                    cts_meta, cts_s;
  logic                    bit_end;
  logic                    can_load;

  assign bit_end  = (cnt == CNT_LAST);
  assign can_load = hold_full && !cts_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      txd_q     <= 1'b1;
      cts_meta  <= 1'b1;
      cts_s     <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      txd_q     <= txd_n;
      cts_meta  <= uart_cts;
      cts_s     <= cts_meta;
    end
  end

  // txd_n is the line level for the coming bit period, so the pin itself stays a plain flop.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shift_n     = shift;
    hold_n      = hold;
    hold_full_n = hold_full;
    txd_n       = txd_q;

    if (uart_tx_valid && !hold_full) begin
      hold_n      = uart_tx_data;
      hold_full_n = 1'b1;
    end

    case (state)
      IDLE: begin
        txd_n = 1'b1;
        cnt_n = '0;
        if (can_load) begin
          state_n     = START;
          shift_n     = hold;
          hold_full_n = 1'b0;
          idx_n       = '0;
          txd_n       = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
          txd_n   = shift[0];
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          if (idx == DATA_LAST) begin
            idx_n   = '0;
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            idx_n = idx + IDX_W'(1);
            txd_n = shift_n[0];
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == STOP_LAST) begin
            // A waiting word goes straight into its start bit with no idle gap.
            if (can_load) begin
              state_n     = START;
              shift_n     = hold;
              hold_full_n = 1'b0;
              idx_n       = '0;
              txd_n       = 1'b0;
            end else begin
              idx_n   = '0;
              state_n = IDLE;
              txd_n   = 1'b1;
            end
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  assign uart_txd      = txd_q;
  assign uart_tx_ready = !hold_full;
  assign uart_tx_busy  = (state != IDLE) || hold_full;

endmodule
